date_counter: RTL and testbench

- Calendar day/month/year counter that sits directly upstream of the month seven-segment decoder.
- cnt_mon drives the decoder's 5-bit month input: binary 1..12, never 0.
- Advances one day per day_tick pulse from the time-of-day counter, with correct month lengths and 2000-2099 leap years.
- Provides a user set mode, driven by debounced button pulses, to adjust each field.

---
 rtl/date_counter.sv | 126 ++++++++++++
 tb/tb_date_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/date_counter.sv
// Calendar day/month/year counter (years 2000-2099) with a run mode driven by
// day_tick and a set mode that bumps one field per inc pulse.
module date_counter #(
    parameter int RESET_DAY  = 1,
    parameter int RESET_MON  = 1,
    parameter int RESET_YEAR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       day_tick,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       inc,
    output logic [4:0] cnt_day,
    output logic [4:0] cnt_mon,
    output logic [6:0] cnt_year,
    output logic       year_wrap
);

    localparam logic [4:0] RST_DAY  = 5'(RESET_DAY);
    localparam logic [4:0] RST_MON  = 5'(RESET_MON);
    localparam logic [6:0] RST_YEAR = 7'(RESET_YEAR);

    typedef enum logic [1:0] {
        SEL_DAY  = 2'd0,
        SEL_MON  = 2'd1,
        SEL_YEAR = 2'd2,
        SEL_NONE = 2'd3
    } sel_t;

    sel_t       sel;
    logic [4:0] day_p0, mon_p0;
    logic [6:0] year_p0;
    logic       wrap_p0;
    logic [4:0] day_nxt, mon_nxt;
    logic [6:0] year_nxt;
    logic       wrap_nxt;
    logic [4:0] days_max;

    // Every year divisible by four in 2000-2099 is a leap year, 2000 included.
    function automatic logic [4:0] month_len(input logic [4:0] mon, input logic [6:0] year);
        case (mon)
            5'd4, 5'd6, 5'd9, 5'd11: month_len = 5'd30;
            5'd2:                    month_len = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 month_len = 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] clamp_day(input logic [4:0] day, input logic [4:0] lim);
        clamp_day = (day > lim) ? lim : day;
    endfunction

    function automatic logic [4:0] wrap_inc5(input logic [4:0] val, input logic [4:0] top);
        wrap_inc5 = (val >= top) ? 5'd1 : val + 5'd1;
    endfunction

    function automatic logic [6:0] wrap_year(input logic [6:0] val);
        wrap_year = (val >= 7'd99) ? 7'd0 : val + 7'd1;
    endfunction

    assign sel      = sel_t'(set_sel);
    assign days_max = month_len(mon_p0, year_p0);

    always_comb begin
        day_nxt  = day_p0;
        mon_nxt  = mon_p0;
        year_nxt = year_p0;
        wrap_nxt = 1'b0;
        if (!set_en) begin
            if (day_tick) begin
                if (day_p0 < days_max) begin
                    day_nxt = day_p0 + 5'd1;
                end else begin
                    day_nxt = 5'd1;
                    if (mon_p0 < 5'd12) begin
                        mon_nxt = mon_p0 + 5'd1;
                    end else begin
                        mon_nxt = 5'd1;
                        if (year_p0 < 7'd99) begin
                            year_nxt = year_p0 + 7'd1;
                        end else begin
                            year_nxt = 7'd0;
                            wrap_nxt = 1'b1;
                        end
                    end
                end
            end
        end else if (inc) begin
            // Set mode never carries between fields; a month or year change
            // pulls the day down if it no longer fits.
            case (sel)
                SEL_DAY: day_nxt = wrap_inc5(day_p0, days_max);
                SEL_MON: begin
                    mon_nxt = wrap_inc5(mon_p0, 5'd12);
                    day_nxt = clamp_day(day_p0, month_len(mon_nxt, year_p0));
                end
                SEL_YEAR: begin
                    year_nxt = wrap_year(year_p0);
                    day_nxt  = clamp_day(day_p0, month_len(mon_p0, year_nxt));
                end
                default: ;
            endcase
        end
    end

    // Stage p0: architectural date registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            day_p0  <= RST_DAY;
            mon_p0  <= RST_MON;
            year_p0 <= RST_YEAR;
            wrap_p0 <= 1'b0;
        end else begin
            day_p0  <= day_nxt;
            mon_p0  <= mon_nxt;
            year_p0 <= year_nxt;
            wrap_p0 <= wrap_nxt;
        end
    end

    assign cnt_day   = day_p0;
    assign cnt_mon   = mon_p0;
    assign cnt_year  = year_p0;
    assign year_wrap = wrap_p0;

endmodule

// File: tb/tb_date_counter.sv
// Bench for date_counter: directed calendar cases plus a randomized run
// compared against a plain-arithmetic calendar model.
module tb_date_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       day_tick = 1'b0;
    logic       set_en = 1'b0;
    logic [1:0] set_sel = 2'd3;
    logic       inc = 1'b0;
    logic [4:0] cnt_day, cnt_mon;
    logic [6:0] cnt_year;
    logic       year_wrap;

    int n_vec = 0;
    int n_bad = 0;
    int m_day, m_mon, m_year, m_wrap;

    date_counter dut (
        .clk      (clk),
        .rst      (rst),
        .day_tick (day_tick),
        .set_en   (set_en),
        .set_sel  (set_sel),
        .inc      (inc),
        .cnt_day  (cnt_day),
        .cnt_mon  (cnt_mon),
        .cnt_year (cnt_year),
        .year_wrap(year_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mlen(input int m, input int y);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && (y % 4) == 0) return 29;
        return t[m-1];
    endfunction

    task automatic model_reset();
        m_day = 1; m_mon = 1; m_year = 0; m_wrap = 0;
    endtask

    task automatic model_edge(input bit tick, input bit sen, input int sel, input bit inc_i);
        m_wrap = 0;
        if (!sen) begin
            if (tick) begin
                m_day++;
                if (m_day > mlen(m_mon, m_year)) begin
                    m_day = 1;
                    m_mon++;
                    if (m_mon > 12) begin
                        m_mon = 1;
                        m_year++;
                        if (m_year > 99) begin
                            m_year = 0;
                            m_wrap = 1;
                        end
                    end
                end
            end
        end else if (inc_i) begin
            case (sel)
                0: begin
                    m_day++;
                    if (m_day > mlen(m_mon, m_year)) m_day = 1;
                end
                1: m_mon = (m_mon % 12) + 1;
                2: m_year = (m_year + 1) % 100;
                default: ;
            endcase
            if (m_day > mlen(m_mon, m_year)) m_day = mlen(m_mon, m_year);
        end
    endtask

    task automatic check_model();
        check("day", int'(cnt_day), m_day);
        check("mon", int'(cnt_mon), m_mon);
        check("year", int'(cnt_year), m_year);
        check("wrap", int'(year_wrap), m_wrap);
    endtask

    task automatic cycle(input bit tick, input bit sen, input int sel, input bit inc_i);
        @(negedge clk);
        day_tick = tick;
        set_en   = sen;
        set_sel  = sel[1:0];
        inc      = inc_i;
        @(posedge clk);
        model_edge(tick, sen, sel, inc_i);
        #1;
        check_model();
    endtask

    task automatic expect_date(input string tag, input int d, input int m, input int y, input int w);
        check({tag, "_day"}, int'(cnt_day), d);
        check({tag, "_mon"}, int'(cnt_mon), m);
        check({tag, "_year"}, int'(cnt_year), y);
        check({tag, "_wrap"}, int'(year_wrap), w);
    endtask

    // Walks the date to d/m/y using set-mode increments only.
    task automatic goto(input int d, input int m, input int y);
        for (int i = 0; i < 120 && m_year != y; i++) cycle(0, 1, 2, 1);
        for (int i = 0; i < 20 && m_mon != m; i++) cycle(0, 1, 1, 1);
        for (int i = 0; i < 40 && m_day != d; i++) cycle(0, 1, 0, 1);
        check("goto", m_day * 10000 + m_mon * 100 + m_year, d * 10000 + m * 100 + y);
    endtask

    initial begin
        int lim;
        bit t, s, n;
        int sl;

        #1 rst = 1'b1;
        #1;
        model_reset();
        expect_date("reset", 1, 1, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Tick burst interrupted by an asynchronous reset between edges.
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
        expect_date("burst", 6, 1, 0, 0);
        @(negedge clk);
        day_tick = 1'b1;
        #2 rst = 1'b1;
        #1 expect_date("async_rst", 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        day_tick = 1'b0;
        model_reset();
        #1 expect_date("post_rst", 1, 1, 0, 0);

        goto(28, 2, 1);
        cycle(1, 0, 0, 0);
        expect_date("feb_nonleap", 1, 3, 1, 0);
        goto(28, 2, 4);
        cycle(1, 0, 0, 0);
        expect_date("feb28_leap", 29, 2, 4, 0);
        cycle(1, 0, 0, 0);
        expect_date("feb29_leap", 1, 3, 4, 0);
        goto(30, 4, 10);
        cycle(1, 0, 0, 0);
        expect_date("apr30", 1, 5, 10, 0);
        goto(31, 12, 99);
        cycle(1, 0, 0, 0);
        expect_date("century", 1, 1, 0, 1);
        cycle(0, 0, 3, 0);
        expect_date("wrap_once", 1, 1, 0, 0);

        goto(31, 1, 1);
        cycle(0, 1, 1, 1);
        expect_date("mon_clamp", 28, 2, 1, 0);
        cycle(0, 1, 0, 1);
        expect_date("day_wrap", 1, 2, 1, 0);
        goto(1, 2, 99);
        cycle(0, 1, 2, 1);
        expect_date("year_set_wrap", 1, 2, 0, 0);

        goto(15, 6, 20);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 3, 0);
        cycle(0, 1, 3, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        expect_date("ignored", 15, 6, 20, 0);

        for (int i = 0; i < 10000; i++) begin
            t  = ($urandom % 2) == 0;
            s  = ($urandom % 3) == 0;
            sl = int'($urandom % 4);
            n  = ($urandom % 2) == 0;
            cycle(t, s, sl, n);
            lim = (cnt_mon >= 1 && cnt_mon <= 12) ? mlen(int'(cnt_mon), int'(cnt_year)) : 31;
            check("inv_mon", int'(cnt_mon >= 1 && cnt_mon <= 12), 1);
            check("inv_day", int'(cnt_day >= 1 && int'(cnt_day) <= lim), 1);
            check("inv_year", int'(cnt_year <= 99), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
